// File: rtl/ram_sdp_clear_pkg.sv
// Shared encodings for the clearing simple-dual-port RAM.
// Holds the read-mode and collision-policy selectors and the clear-sequencer states.
package ram_sdp_clear_pkg;

  localparam int RD_ASYNC = 0;
  localparam int RD_SYNC  = 1;

  localparam int RDW_OLD  = 0;
  localparam int RDW_NEW  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, and holds busy
// until the last location has been written.
module ram_clear_seq
  import ram_sdp_clear_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e    state_q;
  logic          busy_q;
  logic          clr_we_q;
  logic [AW-1:0] clr_addr_q;

  // Busy drops on the same edge that retires the final clear write, so it is high
  // for exactly DEPTH cycles after reset falls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_we_q   <= (CLEAR_ON_RESET != 0);
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            clr_we_q   <= 1'b0;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          clr_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = clr_we_q;
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/ram_sdp_clear.sv
// Simple-dual-port RAM with selectable read latency, configurable read-during-write
// policy and a built-in post-reset clear.
module ram_sdp_clear
  import ram_sdp_clear_pkg::*;
#(
  parameter int  WIDTH          = 2,
  parameter int  DEPTH          = 8,
  parameter int  READ_MODE      = RD_ASYNC,
  parameter int  RDW_MODE       = RDW_OLD,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             busy_o
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;

  logic             waddr_ok;
  logic             raddr_ok;
  logic             user_we;
  logic             mem_we_d;
  logic [AW-1:0]    mem_waddr_d;
  logic [WIDTH-1:0] mem_wdata_d;
  logic [WIDTH-1:0] mem_rd;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign waddr_ok = ({1'b0, waddr_i} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr_i} < DEPTH_W);

  // Rst is included so a request on the very edge that starts a reset is not taken
  // before busy has had a chance to rise.
  assign user_we  = we_i & ~busy & ~rst_i & waddr_ok;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = waddr_i;
    mem_wdata_d = wdata_i;
    if (clr_we) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_addr;
      mem_wdata_d = '0;
    end else if (user_we) begin
      mem_we_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  assign mem_rd = raddr_ok ? mem_q[raddr_i] : '0;

  generate
    if (READ_MODE == RD_SYNC) begin : g_sync_read
      logic [WIDTH-1:0] rdata_q;
      logic [WIDTH-1:0] rdata_d;
      logic             rvalid_q;

      // The array read happens before the write lands, so the old-data policy falls
      // out naturally; the new-data policy forwards the incoming write word.
      always_comb begin
        rdata_d = mem_rd;
        if ((RDW_MODE == RDW_NEW) && user_we && re_i && (waddr_i == raddr_i)) begin
          rdata_d = wdata_i;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (re_i && !busy) begin
          rdata_q  <= rdata_d;
          rvalid_q <= 1'b1;
        end else begin
          rvalid_q <= 1'b0;
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end else begin : g_async_read
      assign rdata_o  = mem_rd;
      assign rvalid_o = re_i & ~busy;
    end
  endgenerate

  assign busy_o = busy;

endmodule

// File: tb/tb_ram_sdp_clear.sv
// Randomised and directed checks of ram_sdp_clear across four configurations sharing
// one stimulus stream, compared against an array/counter reference model.
module tb_ram_sdp_clear;

  localparam int N = 4;

  // Instance table: 0 async D8, 1 sync old-data D8, 2 sync new-data D8, 3 async D6
  int dep   [N] = '{8, 8, 8, 6};
  int rmode [N] = '{0, 1, 1, 0};
  int rdwm  [N] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst, we, re;
  logic [2:0] waddr, raddr;
  logic [1:0] wdata;

  logic [1:0] rdata  [N];
  logic       rvalid [N];
  logic       busy   [N];

  logic [1:0] mem_m     [N][8];
  logic [1:0] rd_m      [N];
  logic       rv_m      [N];
  int         busy_left [N];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_sdp_clear #(.WIDTH(2), .DEPTH(8), .READ_MODE(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_i(raddr), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .busy_o(busy[0]));
  ram_sdp_clear #(.WIDTH(2), .DEPTH(8), .READ_MODE(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u1 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_i(raddr), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .busy_o(busy[1]));
  ram_sdp_clear #(.WIDTH(2), .DEPTH(8), .READ_MODE(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u2 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_i(raddr), .rdata_o(rdata[2]), .rvalid_o(rvalid[2]), .busy_o(busy[2]));
  ram_sdp_clear #(.WIDTH(2), .DEPTH(6), .READ_MODE(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u3 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_i(raddr), .rdata_o(rdata[3]), .rvalid_o(rvalid[3]), .busy_o(busy[3]));

  // Expected outputs derived from the model state and the inputs currently applied
  function automatic logic [1:0] exp_rdata(int i);
    if (rmode[i] == 1) return rd_m[i];
    return (int'(raddr) < dep[i]) ? mem_m[i][raddr] : 2'b00;
  endfunction

  function automatic logic exp_rvalid(int i);
    if (rmode[i] == 1) return rv_m[i];
    return re && (busy_left[i] == 0);
  endfunction

  // Model: reset zeroes the array and arms a DEPTH-cycle busy window; outside that
  // window reads see pre-write contents unless the new-data policy applies.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        busy_left[i] = dep[i];
        rd_m[i]      = 2'b00;
        rv_m[i]      = 1'b0;
        for (int a = 0; a < 8; a++) mem_m[i][a] = 2'b00;
      end else if (busy_left[i] > 0) begin
        busy_left[i] = busy_left[i] - 1;
        rv_m[i]      = 1'b0;
      end else begin
        if (re) begin
          rv_m[i] = 1'b1;
          if (int'(raddr) >= dep[i])                        rd_m[i] = 2'b00;
          else if (rdwm[i] == 1 && we && waddr == raddr)    rd_m[i] = wdata;
          else                                              rd_m[i] = mem_m[i][raddr];
        end else begin
          rv_m[i] = 1'b0;
        end
        if (we && int'(waddr) < dep[i]) mem_m[i][waddr] = wdata;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] wa, input logic [1:0] wd,
                               input logic r, input logic [2:0] ra);
    we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
  endtask

  task automatic test_reset();
    int cnt [N];
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (busy[i] !== 1'b1 || rvalid[i] !== 1'b0) $display("[TB] FAIL reset_state inst%0d: busy=%b rvalid=%b, expected busy=1 rvalid=0", i, busy[i], rvalid[i]);
      else passed++;
      if (rmode[i] == 1) begin
        total++;
        if (rdata[i] !== 2'b00) $display("[TB] FAIL reset_rdata inst%0d: got %0h, expected 0", i, rdata[i]);
        else passed++;
      end
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      logic any;
      any = 1'b0;
      for (int i = 0; i < N; i++) if (busy[i] === 1'b1) begin cnt[i]++; any = 1'b1; end
      if (!any) break;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != dep[i]) $display("[TB] FAIL clear_duration inst%0d: busy %0d cycles, expected %0d", i, cnt[i], dep[i]);
      else passed++;
    end
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'(a));
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (rdata[i] !== 2'b00 || rvalid[i] !== 1'b1) $display("[TB] FAIL cleared_read inst%0d addr%0d: rdata=%0h rvalid=%b, expected 0/1", i, a, rdata[i], rvalid[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_async_rw();
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 3'(a), 2'(a % 4), 1'b0, 3'd0);
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'(a));
      #1;
      total++;
      if (rdata[0] !== 2'(a % 4) || rvalid[0] !== 1'b1) $display("[TB] FAIL async_read addr%0d: rdata=%0h rvalid=%b, expected %0h/1", a, rdata[0], rvalid[0], a % 4);
      else passed++;
      total++;
      if (rdata[3] !== exp_rdata(3)) $display("[TB] FAIL async_read_d6 addr%0d: got %0h, expected %0h", a, rdata[3], exp_rdata(3));
      else passed++;
      tick();
    end
  endtask

  task automatic test_sync_latency();
    applyStimulus(1'b1, 3'd3, 2'b10, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'd3);
    tick();
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    for (int i = 1; i <= 2; i++) begin
      total++;
      if (rdata[i] !== 2'b10 || rvalid[i] !== 1'b1) $display("[TB] FAIL sync_latency inst%0d: rdata=%0h rvalid=%b, expected 2/1", i, rdata[i], rvalid[i]);
      else passed++;
    end
    tick();
    for (int i = 1; i <= 2; i++) begin
      total++;
      if (rdata[i] !== 2'b10 || rvalid[i] !== 1'b0) $display("[TB] FAIL sync_hold inst%0d: rdata=%0h rvalid=%b, expected 2/0", i, rdata[i], rvalid[i]);
      else passed++;
    end
  endtask

  task automatic test_collision();
    applyStimulus(1'b1, 3'd5, 2'b01, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b1, 3'd5, 2'b11, 1'b1, 3'd5);
    tick();
    total++;
    if (rdata[1] !== 2'b01) $display("[TB] FAIL collision_old: got %0h, expected 1", rdata[1]);
    else passed++;
    total++;
    if (rdata[2] !== 2'b11) $display("[TB] FAIL collision_new: got %0h, expected 3", rdata[2]);
    else passed++;
    total++;
    if (rdata[0] !== 2'b11) $display("[TB] FAIL collision_async_after: got %0h, expected 3", rdata[0]);
    else passed++;
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'd5);
    tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (rdata[i] !== 2'b11) $display("[TB] FAIL collision_mem inst%0d: got %0h, expected 3", i, rdata[i]);
      else passed++;
    end
  endtask

  task automatic test_busy_write();
    logic done;
    applyStimulus(1'b1, 3'd2, 2'b11, 1'b0, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 3'd2, 2'b11, 1'b1, 3'd2);
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (busy_left[i] > 0) begin
        total++;
        if (rvalid[i] !== 1'b0 || busy[i] !== 1'b1) $display("[TB] FAIL busy_rvalid inst%0d: rvalid=%b busy=%b, expected 0/1", i, rvalid[i], busy[i]);
        else passed++;
      end
      if (busy[0] === 1'b0) begin done = 1'b1; break; end
    end
    total++;
    if (!done) $display("[TB] FAIL busy_timeout: busy=%b, expected 0 within 20 cycles", busy[0]);
    else passed++;
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rdata[i] !== 2'b00) $display("[TB] FAIL busy_write_dropped inst%0d: got %0h, expected 0", i, rdata[i]);
      else passed++;
    end
    total++;
    if (rdata[3] !== exp_rdata(3)) $display("[TB] FAIL busy_write_d6: got %0h, expected %0h", rdata[3], exp_rdata(3));
    else passed++;
  endtask

  task automatic test_mid_clear();
    int cnt [N];
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      logic any;
      any = 1'b0;
      for (int i = 0; i < N; i++) if (busy[i] === 1'b1) begin cnt[i]++; any = 1'b1; end
      if (!any) break;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != dep[i]) $display("[TB] FAIL restart_duration inst%0d: busy %0d cycles, expected %0d", i, cnt[i], dep[i]);
      else passed++;
    end
    applyStimulus(1'b1, 3'd7, 2'b11, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'd7);
    tick();
    total++;
    if (rdata[3] !== 2'b00 || rvalid[3] !== 1'b1) $display("[TB] FAIL oor_read_d6: rdata=%0h rvalid=%b, expected 0/1", rdata[3], rvalid[3]);
    else passed++;
    total++;
    if (rdata[0] !== 2'b11) $display("[TB] FAIL inrange_read_d8: got %0h, expected 3", rdata[0]);
    else passed++;
    for (int a = 0; a < 6; a++) begin
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 3'(a));
      #1;
      total++;
      if (rdata[3] !== 2'b00) $display("[TB] FAIL oor_no_alias addr%0d: got %0h, expected 0", a, rdata[3]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      if (($urandom % 4) == 0) raddr = waddr;
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (rvalid[i] !== exp_rvalid(i) || busy[i] !== (busy_left[i] > 0) ||
            (exp_rvalid(i) && rdata[i] !== exp_rdata(i)) || (rmode[i] == 1 && rdata[i] !== exp_rdata(i)))
          $display("[TB] FAIL random c%0d inst%0d: rdata=%0h rvalid=%b busy=%b, expected %0h/%b/%b",
                   c, i, rdata[i], rvalid[i], busy[i], exp_rdata(i), exp_rvalid(i), busy_left[i] > 0);
        else passed++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    test_reset();
    test_async_rw();
    test_sync_latency();
    test_collision();
    test_busy_write();
    test_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
